// File: rtl/add_share_pkg.sv
// Shared types and constants for the add_share_arbiter block.
package add_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int STATS_W = 16;

endpackage

// File: rtl/add_share_arbiter_rca.sv
// Parameterised ripple-carry adder (fulladd4 generalised to WIDTH bits).
module rca_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    always_comb begin
        logic [WIDTH:0] carry;
        carry    = '0;
        carry[0] = cin_i;
        sum_o    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry[WIDTH];
    end

endmodule

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter sharing one rca_adder among N_REQ requesters (IDLE/CALC/RESP).
// Optional grant counter output enabled by defining ADD_SHARE_STATS_EN.
module add_share_arbiter
    import add_share_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 4,
    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*WIDTH-1:0] req_a_i,
    input  logic [N_REQ*WIDTH-1:0] req_b_i,
    input  logic [N_REQ-1:0]       req_cin_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [WIDTH-1:0]       resp_sum_o,
    output logic                   resp_cout_o,
    output logic [IDW-1:0]         resp_id_o
`ifdef ADD_SHARE_STATS_EN
    ,
    output logic [STATS_W-1:0]     grant_cnt_o
`endif
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_sum_q, resp_sum_d;
    logic             resp_cout_q, resp_cout_d;
    logic [IDW-1:0]   resp_id_q, resp_id_d;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    rca_adder #(.WIDTH(WIDTH)) u_rca_adder (
        .a_i    (a_q),
        .b_i    (b_q),
        .cin_i  (cin_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // First valid requester scanning upward from rr_ptr, wrapping at N_REQ.
    always_comb begin
        logic [IDW-1:0] k;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        k         = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = IDW'((int'(rr_ptr_q) + i) % N_REQ);
            if (!gnt_found && req_valid_i[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = k;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (reset_ni && (state_q == IDLE) && gnt_found) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        resp_valid_d = resp_valid_q;
        resp_sum_d   = resp_sum_q;
        resp_cout_d  = resp_cout_q;
        resp_id_d    = resp_id_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    id_d    = gnt_idx;
                    a_d     = WIDTH'(req_a_i >> (int'(gnt_idx) * WIDTH));
                    b_d     = WIDTH'(req_b_i >> (int'(gnt_idx) * WIDTH));
                    cin_d   = req_cin_i[gnt_idx];
                    state_d = CALC;
                end
            end
            CALC: begin
                resp_sum_d   = add_sum;
                resp_cout_d  = add_cout;
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    rr_ptr_d     = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_sum_q   <= '0;
            resp_cout_q  <= 1'b0;
            resp_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_sum_q   <= resp_sum_d;
            resp_cout_q  <= resp_cout_d;
            resp_id_q    <= resp_id_d;
        end
    end

    // Captured operands only matter after a grant, so they carry no reset.
    always_ff @(posedge clk_i) begin
        id_q  <= id_d;
        a_q   <= a_d;
        b_q   <= b_d;
        cin_q <= cin_d;
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_sum_o   = resp_sum_q;
    assign resp_cout_o  = resp_cout_q;
    assign resp_id_o    = resp_id_q;

`ifdef ADD_SHARE_STATS_EN
    logic [STATS_W-1:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if ((state_q == IDLE) && gnt_found && (grant_cnt_q != '1)) begin
            grant_cnt_d = grant_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed testbench for add_share_arbiter (N_REQ=4, WIDTH=4).
module tb_add_share_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [3:0]  req_valid_i;
    logic [3:0]  req_ready_o;
    logic [15:0] req_a_i;
    logic [15:0] req_b_i;
    logic [3:0]  req_cin_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [3:0]  resp_sum_o;
    logic        resp_cout_o;
    logic [1:0]  resp_id_o;
`ifdef ADD_SHARE_STATS_EN
    logic [15:0] grant_cnt_o;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    add_share_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .req_cin_i    (req_cin_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_sum_o   (resp_sum_o),
        .resp_cout_o  (resp_cout_o),
        .resp_id_o    (resp_id_o)
`ifdef ADD_SHARE_STATS_EN
        ,
        .grant_cnt_o  (grant_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Fairness table: a = {8,5,3,1}, b = {9,6,4,2}, cin = 4'b1010
    logic [3:0] exp_sum  [4] = '{4'h3, 4'h8, 4'hB, 4'h2};
    logic       exp_cout [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset_ni     = 1'b0;
        req_valid_i  = 4'hF;
        req_a_i      = '0;
        req_b_i      = '0;
        req_cin_i    = '0;
        resp_ready_i = 1'b1;

        // Reset held for two edges with requests pending
        cyc();
        cyc();
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'h0);
        chk("rst_valid", 32'(resp_valid_o), 32'h0);
        chk("rst_sum", 32'(resp_sum_o), 32'h0);
        chk("rst_cout", 32'(resp_cout_o), 32'h0);
        chk("rst_id", 32'(resp_id_o), 32'h0);
        reset_ni    = 1'b1;
        req_valid_i = 4'h0;
        #1;
        chk("idle_ready0", 32'(req_ready_o), 32'h0);
        cyc();
        #1;
        chk("idle_ready1", 32'(req_ready_o), 32'h0);

        // Single request from requester 2: A + 7 + 1 = 0x12
        cyc();
        req_valid_i = 4'b0100;
        req_a_i     = 16'h0A00;
        req_b_i     = 16'h0700;
        req_cin_i   = 4'b0100;
        #1;
        chk("single_grant", 32'(req_ready_o), 32'h4);
        cyc();
        req_valid_i = 4'h0;
        #1;
        chk("single_calc_ready", 32'(req_ready_o), 32'h0);
        chk("single_calc_valid", 32'(resp_valid_o), 32'h0);
        cyc();
        #1;
        chk("single_valid", 32'(resp_valid_o), 32'h1);
        chk("single_sum", 32'(resp_sum_o), 32'h2);
        chk("single_cout", 32'(resp_cout_o), 32'h1);
        chk("single_id", 32'(resp_id_o), 32'h2);
        cyc();
        #1;
        chk("single_done", 32'(resp_valid_o), 32'h0);

        // Reset to bring rr_ptr back to 0 before the fairness run
        reset_ni = 1'b0;
        cyc();
        reset_ni    = 1'b1;
        req_valid_i = 4'hF;
        req_a_i     = 16'h8531;
        req_b_i     = 16'h9642;
        req_cin_i   = 4'b1010;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk($sformatf("fair_grant%0d", n), 32'(req_ready_o), 32'(1 << (n % 4)));
            cyc();
            #1;
            chk($sformatf("fair_calc%0d", n), 32'({resp_valid_o, req_ready_o}), 32'h0);
            cyc();
            #1;
            chk($sformatf("fair_valid%0d", n), 32'(resp_valid_o), 32'h1);
            chk($sformatf("fair_id%0d", n), 32'(resp_id_o), 32'(n % 4));
            chk($sformatf("fair_sum%0d", n), 32'({resp_cout_o, resp_sum_o}),
                32'({exp_cout[n % 4], exp_sum[n % 4]}));
            chk($sformatf("fair_rdy%0d", n), 32'(req_ready_o), 32'h0);
            cyc();
        end

        // Backpressure: grant to 1, hold RESP five cycles
        resp_ready_i = 1'b0;
        #1;
`ifdef ADD_SHARE_STATS_EN
        chk("stats_cnt5", 32'(grant_cnt_o), 32'd5);
`endif
        chk("bp_grant", 32'(req_ready_o), 32'h2);
        cyc();
        #1;
        chk("bp_calc", 32'(resp_valid_o), 32'h0);
        for (int n = 0; n < 5; n++) begin
            cyc();
            #1;
            chk($sformatf("bp_hold_valid%0d", n), 32'(resp_valid_o), 32'h1);
            chk($sformatf("bp_hold_data%0d", n), 32'({resp_id_o, resp_cout_o, resp_sum_o}),
                32'({2'd1, 1'b0, 4'h8}));
            chk($sformatf("bp_hold_rdy%0d", n), 32'(req_ready_o), 32'h0);
        end
        cyc();
        resp_ready_i = 1'b1;
        #1;
        chk("bp_accept_valid", 32'(resp_valid_o), 32'h1);
        cyc();
        #1;
        chk("bp_resume_grant", 32'(req_ready_o), 32'h4);
        chk("bp_resume_valid", 32'(resp_valid_o), 32'h0);
        cyc();
        cyc();
        #1;
        chk("bp_next_data", 32'({resp_id_o, resp_cout_o, resp_sum_o}), 32'({2'd2, 1'b0, 4'hB}));

        // Reset pulsed in CALC of requester 3's transaction
        cyc();
        #1;
        chk("mid_grant3", 32'(req_ready_o), 32'h8);
        cyc();
        reset_ni = 1'b0;
        #1;
        chk("mid_calc_ready", 32'(req_ready_o), 32'h0);
        cyc();
        reset_ni    = 1'b1;
        req_valid_i = 4'b1010;
        #1;
        chk("mid_no_valid", 32'(resp_valid_o), 32'h0);
        chk("mid_sum_clr", 32'(resp_sum_o), 32'h0);
        chk("mid_lowest_grant", 32'(req_ready_o), 32'h2);
        cyc();
        req_valid_i = 4'h0;
        #1;
        chk("mid_calc_valid", 32'(resp_valid_o), 32'h0);
        cyc();
        #1;
        chk("mid_resp_valid", 32'(resp_valid_o), 32'h1);
        chk("mid_resp_data", 32'({resp_id_o, resp_cout_o, resp_sum_o}), 32'({2'd1, 1'b0, 4'h8}));
`ifdef ADD_SHARE_STATS_EN
        chk("stats_cnt1", 32'(grant_cnt_o), 32'd1);
`endif
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
